// File: rtl/uart_tx_buffer_pkg.sv
// Shared definitions for the UART transmit buffer: send-sequencer state
// encodings and the default FIFO depth.
package uart_tx_buffer_pkg;

  localparam int unsigned DEPTH_LOG2_DEF = 4;
  localparam int unsigned DATA_W_DEF     = 8;

  typedef logic [1:0] state_t;

  localparam state_t IDLE      = 2'd0;
  localparam state_t ISSUE     = 2'd1;
  localparam state_t WAIT_BUSY = 2'd2;
  localparam state_t WAIT_DONE = 2'd3;

endpackage

// File: rtl/uart_tx_buffer_if.sv
// Bus bundle between the byte producer / UART transmitter and the buffer.
// master: producer + transmitter side (drives WR_EN, WR_DATA, TX_READY).
// slave : buffer side (drives FULL, EMPTY, COUNT, OVERFLOW, BUSY, TX_SEND, TX_DATA).
interface uart_tx_buffer_if
  import uart_tx_buffer_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF
);

  logic              WR_EN;
  logic [DATA_W-1:0] WR_DATA;
  logic              FULL;
  logic              EMPTY;
  logic [DEPTH_LOG2:0] COUNT;
  logic              OVERFLOW;
  logic              BUSY;
  logic              TX_READY;
  logic              TX_SEND;
  logic [DATA_W-1:0] TX_DATA;

  modport master (
    output WR_EN, WR_DATA, TX_READY,
    input  FULL, EMPTY, COUNT, OVERFLOW, BUSY, TX_SEND, TX_DATA
  );

  modport slave (
    input  WR_EN, WR_DATA, TX_READY,
    output FULL, EMPTY, COUNT, OVERFLOW, BUSY, TX_SEND, TX_DATA
  );

endinterface

// File: rtl/uart_tx_buffer_sync_fifo.sv
// Synchronous FIFO with registered occupancy flags; no fall-through.
// Ports: CLK, RST (sync active-high), push/din write side, pop/dout read side
// (dout is the current head), full/empty/count registered status.
module uart_tx_buffer_sync_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned DATA_W     = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [DEPTH_LOG2:0] count
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned PW    = DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wrPtr;
  logic [PW-1:0]     rdPtr;
  logic [CW-1:0]     countNext;
  logic              pushOk;
  logic              popOk;

  // A push while full is dropped even if a pop happens in the same cycle.
  assign pushOk = push & ~full;
  assign popOk  = pop & ~empty;
  assign dout   = mem[rdPtr];

  always_comb begin
    countNext = count;
    case ({pushOk, popOk})
      2'b10:   countNext = count + CW'(1);
      2'b01:   countNext = count - CW'(1);
      default: countNext = count;
    endcase
  end

  // Pointers, occupancy and flags.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (pushOk) wrPtr <= wrPtr + PW'(1);
      if (popOk)  rdPtr <= rdPtr + PW'(1);
      count <= countNext;
      full  <= (countNext == CW'(DEPTH));
      empty <= (countNext == '0);
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge CLK) begin
    if (pushOk) mem[wrPtr] <= din;
  end

endmodule

// File: rtl/uart_tx_buffer.sv
// Byte buffer and send sequencer in front of the UART transmitter.
// Ports: CLK, RST (sync active-high), bus (slave modport): WR_EN/WR_DATA
// write strobe, FULL/EMPTY/COUNT/OVERFLOW status, BUSY (sequencer not idle),
// TX_READY/TX_SEND/TX_DATA transmitter handshake.
module uart_tx_buffer
  import uart_tx_buffer_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  uart_tx_buffer_if.slave  bus
);

  state_t              state;
  state_t              stateNext;
  logic                popC;
  logic                sendNext;
  logic                busyNext;
  logic                overflowNext;
  logic                txSend;
  logic                busy;
  logic                overflow;
  logic [DATA_W-1:0]   txData;
  logic [DATA_W-1:0]   fifoDout;
  logic                fifoFull;
  logic                fifoEmpty;
  logic [DEPTH_LOG2:0] fifoCount;

  uart_tx_buffer_sync_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .DATA_W     (DATA_W)
  ) uFifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (bus.WR_EN),
    .pop   (popC),
    .din   (bus.WR_DATA),
    .dout  (fifoDout),
    .full  (fifoFull),
    .empty (fifoEmpty),
    .count (fifoCount)
  );

  assign bus.FULL     = fifoFull;
  assign bus.EMPTY    = fifoEmpty;
  assign bus.COUNT    = fifoCount;
  assign bus.OVERFLOW = overflow;
  assign bus.BUSY     = busy;
  assign bus.TX_SEND  = txSend;
  assign bus.TX_DATA  = txData;

  // State register plus registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      txSend   <= 1'b0;
      busy     <= 1'b0;
      overflow <= 1'b0;
      txData   <= '0;
    end else begin
      state    <= stateNext;
      txSend   <= sendNext;
      busy     <= busyNext;
      overflow <= overflowNext;
      if (popC) txData <= fifoDout;
    end
  end

  // Next-state logic; the transmitter drops READY one cycle after SEND.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:      if (!fifoEmpty && bus.TX_READY) stateNext = ISSUE;
      ISSUE:     stateNext = WAIT_BUSY;
      WAIT_BUSY: if (!bus.TX_READY) stateNext = WAIT_DONE;
      WAIT_DONE: if (bus.TX_READY) stateNext = IDLE;
      default:   stateNext = IDLE;
    endcase
  end

  // Output decode; SEND is high only for the single cycle spent in ISSUE.
  always_comb begin
    popC         = 1'b0;
    sendNext     = 1'b0;
    busyNext     = 1'b0;
    overflowNext = overflow;
    popC         = (state == IDLE) && !fifoEmpty && bus.TX_READY;
    sendNext     = (stateNext == ISSUE);
    busyNext     = (stateNext != IDLE);
    overflowNext = overflow | (bus.WR_EN & fifoFull);
  end

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Self-checking bench for uart_tx_buffer with a behavioural transmitter:
// READY drops the cycle after SEND and stays low for txLen cycles, or is
// held low while 'hold' is set.
module tb_uart_tx_buffer;

  logic CLK = 1'b0;
  logic RST;

  always #5 CLK = ~CLK;

  uart_tx_buffer_if #(.DEPTH_LOG2(4), .DATA_W(8)) bus ();

  uart_tx_buffer #(.DEPTH_LOG2(4), .DATA_W(8)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int nChecks = 0;
  int nFail   = 0;

  int         txLen    = 3;
  bit         hold     = 1'b0;
  bit         dropNext = 1'b0;
  int         left     = 0;
  logic [7:0] sentQ [$];

  typedef struct {
    logic       wrEn;
    logic [7:0] wrData;
    logic       expSend;
    logic [7:0] expData;
    logic       expBusy;
    logic       expEmpty;
    logic [4:0] expCount;
  } vec_t;

  vec_t vecs [17];

  // Transmitter model, evaluated late in each cycle.
  initial begin
    bus.TX_READY = 1'b1;
    forever begin
      @(posedge CLK);
      #3;
      if (dropNext) begin
        bus.TX_READY = 1'b0;
        dropNext     = 1'b0;
        left         = txLen;
      end else if (left > 0) begin
        left = left - 1;
      end
      if (hold) bus.TX_READY = 1'b0;
      else if (left == 0 && !dropNext) bus.TX_READY = 1'b1;
      if (bus.TX_SEND) begin
        sentQ.push_back(bus.TX_DATA);
        dropNext = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic waitIdle(input int limit);
    int n = 0;
    while (!(bus.BUSY == 1'b0 && bus.EMPTY == 1'b1 && bus.TX_READY == 1'b1) && n < limit) begin
      tick();
      n++;
    end
    chk("drain_in_time", 32'(n < limit), 32'd1);
  endtask

  task automatic write(input logic [7:0] d);
    bus.WR_EN   = 1'b1;
    bus.WR_DATA = d;
    tick();
    bus.WR_EN   = 1'b0;
  endtask

  initial begin
    int bad;

    // Single byte A5, then two back-to-back bytes 11/22 (txLen = 3).
    vecs[0]  = '{1'b1, 8'hA5, 1'b0, 8'h00, 1'b0, 1'b0, 5'd1};
    vecs[1]  = '{1'b0, 8'h00, 1'b1, 8'hA5, 1'b1, 1'b1, 5'd0};
    vecs[2]  = '{1'b0, 8'h00, 1'b0, 8'hA5, 1'b1, 1'b1, 5'd0};
    vecs[3]  = '{1'b0, 8'h00, 1'b0, 8'hA5, 1'b1, 1'b1, 5'd0};
    vecs[4]  = '{1'b0, 8'h00, 1'b0, 8'hA5, 1'b1, 1'b1, 5'd0};
    vecs[5]  = '{1'b0, 8'h00, 1'b0, 8'hA5, 1'b1, 1'b1, 5'd0};
    vecs[6]  = '{1'b0, 8'h00, 1'b0, 8'hA5, 1'b0, 1'b1, 5'd0};
    vecs[7]  = '{1'b0, 8'h00, 1'b0, 8'hA5, 1'b0, 1'b1, 5'd0};
    vecs[8]  = '{1'b1, 8'h11, 1'b0, 8'hA5, 1'b0, 1'b0, 5'd1};
    vecs[9]  = '{1'b1, 8'h22, 1'b1, 8'h11, 1'b1, 1'b0, 5'd1};
    vecs[10] = '{1'b0, 8'h00, 1'b0, 8'h11, 1'b1, 1'b0, 5'd1};
    vecs[11] = '{1'b0, 8'h00, 1'b0, 8'h11, 1'b1, 1'b0, 5'd1};
    vecs[12] = '{1'b0, 8'h00, 1'b0, 8'h11, 1'b1, 1'b0, 5'd1};
    vecs[13] = '{1'b0, 8'h00, 1'b0, 8'h11, 1'b1, 1'b0, 5'd1};
    vecs[14] = '{1'b0, 8'h00, 1'b0, 8'h11, 1'b0, 1'b0, 5'd1};
    vecs[15] = '{1'b0, 8'h00, 1'b1, 8'h22, 1'b1, 1'b1, 5'd0};
    vecs[16] = '{1'b0, 8'h00, 1'b0, 8'h22, 1'b1, 1'b1, 5'd0};

    RST         = 1'b1;
    bus.WR_EN   = 1'b0;
    bus.WR_DATA = 8'h00;
    repeat (3) tick();
    RST = 1'b0;

    // Reset state.
    chk("rst_empty",    32'(bus.EMPTY),    32'd1);
    chk("rst_full",     32'(bus.FULL),     32'd0);
    chk("rst_count",    32'(bus.COUNT),    32'd0);
    chk("rst_overflow", 32'(bus.OVERFLOW), 32'd0);
    chk("rst_busy",     32'(bus.BUSY),     32'd0);
    chk("rst_send",     32'(bus.TX_SEND),  32'd0);
    chk("rst_data",     32'(bus.TX_DATA),  32'h00);

    // Idle for 100 cycles: no sends.
    repeat (100) tick();
    chk("idle_nosend", 32'(sentQ.size()), 32'd0);
    chk("idle_empty",  32'(bus.EMPTY),    32'd1);

    // Table-driven cycle-by-cycle vectors.
    for (int i = 0; i < 17; i++) begin
      bus.WR_EN   = vecs[i].wrEn;
      bus.WR_DATA = vecs[i].wrData;
      tick();
      chk($sformatf("vec%0d_send",  i), 32'(bus.TX_SEND), 32'(vecs[i].expSend));
      chk($sformatf("vec%0d_data",  i), 32'(bus.TX_DATA), 32'(vecs[i].expData));
      chk($sformatf("vec%0d_busy",  i), 32'(bus.BUSY),    32'(vecs[i].expBusy));
      chk($sformatf("vec%0d_empty", i), 32'(bus.EMPTY),   32'(vecs[i].expEmpty));
      chk($sformatf("vec%0d_count", i), 32'(bus.COUNT),   32'(vecs[i].expCount));
    end
    bus.WR_EN = 1'b0;
    waitIdle(200);
    chk("vec_sent_total", 32'(sentQ.size()), 32'd3);

    // Burst of 16 with transmitter held busy, then one write while full.
    sentQ.delete();
    hold = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) write(8'(i));
    chk("burst_full",  32'(bus.FULL),     32'd1);
    chk("burst_count", 32'(bus.COUNT),    32'd16);
    chk("burst_ovf0",  32'(bus.OVERFLOW), 32'd0);
    write(8'hFF);
    chk("ovf_set",        32'(bus.OVERFLOW), 32'd1);
    chk("ovf_count_kept", 32'(bus.COUNT),    32'd16);
    hold = 1'b0;
    waitIdle(2000);
    chk("burst_sent_n", 32'(sentQ.size()), 32'd16);
    for (int i = 0; i < 16; i++)
      chk($sformatf("burst_byte%0d", i),
          (i < sentQ.size()) ? 32'(sentQ[i]) : 32'hDEAD, 32'(i));
    chk("ovf_sticky_after_drain", 32'(bus.OVERFLOW), 32'd1);

    // Simultaneous push and pop at COUNT=5.
    sentQ.delete();
    hold = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) write(8'h31 + 8'(i));
    tick();
    chk("pp_pre_count", 32'(bus.COUNT), 32'd5);
    hold        = 1'b0;
    bus.WR_EN   = 1'b1;
    bus.WR_DATA = 8'h36;
    tick();
    bus.WR_EN = 1'b0;
    chk("pp_count", 32'(bus.COUNT),   32'd5);
    chk("pp_send",  32'(bus.TX_SEND), 32'd1);
    chk("pp_data",  32'(bus.TX_DATA), 32'h31);
    waitIdle(1000);
    chk("pp_sent_n", 32'(sentQ.size()), 32'd6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("pp_byte%0d", i),
          (i < sentQ.size()) ? 32'(sentQ[i]) : 32'hDEAD, 32'h31 + 32'(i));

    // READY held low for 500 cycles after an issue.
    sentQ.delete();
    write(8'h4A);
    write(8'h4B);
    chk("stall_send", 32'(bus.TX_SEND), 32'd1);
    chk("stall_data", 32'(bus.TX_DATA), 32'h4A);
    tick();
    hold = 1'b1;
    bad  = 0;
    repeat (500) begin
      tick();
      if (bus.TX_SEND !== 1'b0 || bus.COUNT !== 5'd1 || bus.BUSY !== 1'b1) bad++;
    end
    chk("stall_hold_bad_cycles", 32'(bad), 32'd0);
    chk("stall_sent_n", 32'(sentQ.size()), 32'd1);
    hold = 1'b0;
    tick();
    chk("release_plus1_send", 32'(bus.TX_SEND), 32'd0);
    tick();
    chk("release_plus2_send", 32'(bus.TX_SEND), 32'd1);
    chk("release_plus2_data", 32'(bus.TX_DATA), 32'h4B);
    waitIdle(200);

    // Reset while in WAIT_DONE with 3 bytes queued.
    sentQ.delete();
    chk("pre_rst_ovf", 32'(bus.OVERFLOW), 32'd1);
    write(8'h50);
    tick();
    chk("wd_send", 32'(bus.TX_SEND), 32'd1);
    tick();
    hold = 1'b1;
    write(8'h51);
    write(8'h52);
    write(8'h53);
    tick();
    chk("wd_count", 32'(bus.COUNT), 32'd3);
    chk("wd_busy",  32'(bus.BUSY),  32'd1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("mrst_count", 32'(bus.COUNT),    32'd0);
    chk("mrst_empty", 32'(bus.EMPTY),    32'd1);
    chk("mrst_ovf",   32'(bus.OVERFLOW), 32'd0);
    chk("mrst_busy",  32'(bus.BUSY),     32'd0);
    chk("mrst_send",  32'(bus.TX_SEND),  32'd0);
    hold = 1'b0;
    repeat (50) tick();
    chk("mrst_no_send", 32'(sentQ.size()), 32'd1);
    write(8'h60);
    waitIdle(200);
    chk("post_rst_sent_n", 32'(sentQ.size()), 32'd2);
    chk("post_rst_byte", (sentQ.size() > 1) ? 32'(sentQ[1]) : 32'hDEAD, 32'h60);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
